// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a downstream JK flip-flop, one command per flip-flop edge,
// with a reference model of Q that checks the read-back value and counts errors.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_clear_err,
    input  logic             i_q_in,
    output logic             o_j,
    output logic             o_k,
    output logic             o_busy,
    output logic             o_exp_q,
    output logic             o_mismatch,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_cmd_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_occ;
    logic [1:0]       r_cur_cmd;
    logic             r_j, r_k, r_exp_q, r_mismatch;
    logic [CNT_W-1:0] r_err, r_cnt;
    logic             w_push, w_pop, w_empty, w_fail;
    logic [1:0]       w_head;

    assign w_empty     = (r_occ == '0);
    assign o_cmd_ready = (r_occ != OCC_FULL);
    assign w_push      = i_cmd_valid & o_cmd_ready;
    assign w_head      = r_mem[r_rptr];
    assign w_fail      = (r_state == S_CHECK) && (i_q_in != r_exp_q);

    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_exp_q     = r_exp_q;
    assign o_mismatch  = r_mismatch;
    assign o_err_count = r_err;
    assign o_cmd_count = r_cnt;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_cmd;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_cur_cmd <= 2'b00;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_pop) r_cur_cmd <= w_head;
            // J/K are live only for the DRIVE cycle that follows a pop.
            r_j <= w_pop & w_head[1];
            r_k <= w_pop & w_head[0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_exp_q    <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
            r_cnt      <= '0;
        end else begin
            if (r_state == S_DRIVE) begin
                case (r_cur_cmd)
                    2'b01:   r_exp_q <= 1'b0;
                    2'b10:   r_exp_q <= 1'b1;
                    2'b11:   r_exp_q <= ~r_exp_q;
                    default: r_exp_q <= r_exp_q;
                endcase
            end
            if (r_state == S_CHECK) r_cnt <= r_cnt + CNT_W'(1);
            // A failure landing on a clear restarts the count at one.
            if (w_fail) begin
                r_mismatch <= 1'b1;
                if (i_clear_err)    r_err <= CNT_W'(1);
                else if (r_err != '1) r_err <= r_err + CNT_W'(1);
            end else if (i_clear_err) begin
                r_mismatch <= 1'b0;
                r_err      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: schedule-based reference model, vector table and
// directed corner sequences, with a CNT_W=2 twin checking counter limits.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, clear_err, q_in;
    logic [1:0] cmd;
    logic       rdy, j, k, busy, expq, mis;
    logic [7:0] err, cnt;
    logic       rdy2, j2, k2, busy2, expq2, mis2;
    logic [1:0] err2, cnt2;
    logic       ff_q, stuck, q_inv;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(rdy), .i_clear_err(clear_err), .i_q_in(q_in),
        .o_j(j), .o_k(k), .o_busy(busy), .o_exp_q(expq), .o_mismatch(mis),
        .o_err_count(err), .o_cmd_count(cnt));

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(rdy2), .i_clear_err(clear_err), .i_q_in(q_in),
        .o_j(j2), .o_k(k2), .o_busy(busy2), .o_exp_q(expq2), .o_mismatch(mis2),
        .o_err_count(err2), .o_cmd_count(cnt2));

    // Downstream JK flip-flop
    always @(posedge clk or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else case ({j, k})
            2'b01: ff_q <= 1'b0;
            2'b10: ff_q <= 1'b1;
            2'b11: ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end
    assign q_in = (stuck ? 1'b0 : ff_q) ^ q_inv;

    // Model: each accepted command is popped at max(push+1, prev_pop+2),
    // drives J/K for that cycle, updates Q at pop+1, is checked at pop+2.
    typedef struct { logic [1:0] cmd; int pop; } ent_t;
    ent_t mq[$];
    int   n = 0, last_pop, m_err8, m_err2, m_cnt;
    bit   m_exp, m_mis;
    int   checks = 0, errors = 0;
    logic [1:0] obs_jk[$];
    logic       obs_q[$];
    bit   last_acc;

    typedef struct { logic [1:0] cmd; logic [1:0] jk; logic q; } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int occ_after();
        int c = 0;
        foreach (mq[i]) if (mq[i].pop > n) c++;
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        last_pop = -1000000;
        m_exp = 0; m_mis = 0; m_err8 = 0; m_err2 = 0; m_cnt = 0;
    endtask

    task automatic step(input bit v, input logic [1:0] c, input bit clr);
        int occ_b, ejk;
        bit acc, fail, qpre;
        ent_t e;
        cmd_valid = v; cmd = c; clear_err = clr;
        #1;
        occ_b = occ_after();
        acc   = v && (occ_b != DEPTH);
        qpre  = q_in;
        chk("cmd_ready", rdy, occ_b != DEPTH);
        @(posedge clk);
        n++;
        fail = 0;
        foreach (mq[i]) if (mq[i].pop + 2 == n) begin
            m_cnt++;
            if (qpre != m_exp) fail = 1;
        end
        foreach (mq[i]) if (mq[i].pop + 1 == n) begin
            case (mq[i].cmd)
                2'b01: m_exp = 0;
                2'b10: m_exp = 1;
                2'b11: m_exp = ~m_exp;
                default: ;
            endcase
        end
        if (fail) begin
            m_mis = 1;
            if (clr) begin m_err8 = 1; m_err2 = 1; end
            else begin
                if (m_err8 < 255) m_err8++;
                if (m_err2 < 3)   m_err2++;
            end
        end else if (clr) begin
            m_mis = 0; m_err8 = 0; m_err2 = 0;
        end
        while (mq.size() > 0 && mq[0].pop + 2 <= n) void'(mq.pop_front());
        if (acc) begin
            e.cmd = c;
            e.pop = (n + 1 > last_pop + 2) ? n + 1 : last_pop + 2;
            mq.push_back(e);
            last_pop = e.pop;
        end
        last_acc = acc;
        #1;
        ejk = 0;
        foreach (mq[i]) begin
            if (mq[i].pop == n) begin ejk = mq[i].cmd; obs_jk.push_back({j, k}); end
            if (mq[i].pop + 1 == n) obs_q.push_back(expq);
        end
        chk("jk", {j, k}, ejk);
        chk("exp_q", expq, m_exp);
        chk("busy", busy, mq.size() != 0);
        chk("mismatch", mis, m_mis);
        chk("err_count", err, m_err8);
        chk("cmd_count", cnt, m_cnt % 256);
        chk("err_count_w2", err2, m_err2);
        chk("cmd_count_w2", cnt2, m_cnt % 4);
        chk("mismatch_w2", mis2, m_mis);
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0; clear_err = 0; cmd = 2'b00; stuck = 0; q_inv = 0;
        model_reset();
        @(posedge clk); @(posedge clk);
        n += 2;
        #1 rst = 0;
        obs_jk.delete(); obs_q.delete();
    endtask

    task automatic push_cmd(input logic [1:0] c);
        last_acc = 0;
        for (int t = 0; t < 20 && !last_acc; t++) step(1, c, 0);
        if (!last_acc) chk("push_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && mq.size() != 0; t++) step(0, 2'b00, 0);
        if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
        step(0, 2'b00, 0);
    endtask

    initial begin
        int  acc_cnt, p;
        bit  saw_low, hit;
        tbl[0] = '{2'b00, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 2'b01, 1'b0};
        tbl[2] = '{2'b10, 2'b10, 1'b1};
        tbl[3] = '{2'b11, 2'b11, 1'b0};
        tbl[4] = '{2'b00, 2'b00, 1'b0};
        tbl[5] = '{2'b01, 2'b01, 1'b0};
        tbl[6] = '{2'b10, 2'b10, 1'b1};
        tbl[7] = '{2'b11, 2'b11, 1'b0};

        // Reset values, then asynchronous reset while DRIVE with 3 queued
        do_reset();
        #1;
        chk("rst_ready", rdy, 1); chk("rst_busy", busy, 0);
        chk("rst_jk", {j, k}, 0); chk("rst_expq", expq, 0);
        chk("rst_err", err, 0); chk("rst_cnt", cnt, 0); chk("rst_mis", mis, 0);
        hit = 0;
        for (int t = 0; t < 12 && !hit; t++) begin
            step(1, 2'b10, 0);
            foreach (mq[i]) if (mq[i].pop == n && occ_after() >= 3) hit = 1;
        end
        chk("rst_setup_reached", hit, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_j", j, 0); chk("async_rst_k", k, 0);
        chk("async_rst_ready", rdy, 1);
        do_reset();
        for (int t = 0; t < 4; t++) step(0, 2'b00, 0);
        chk("post_rst_cnt", cnt, 0); chk("post_rst_busy", busy, 0);

        // Command sequence against a working flip-flop
        do_reset();
        foreach (tbl[i]) push_cmd(tbl[i].cmd);
        drain();
        chk("seq_obs_count", obs_jk.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_jk.size()) chk("seq_jk", obs_jk[i], tbl[i].jk);
            if (i < obs_q.size())  chk("seq_q", obs_q[i], tbl[i].q);
        end
        chk("seq_cnt", cnt, 8); chk("seq_err", err, 0); chk("seq_mis", mis, 0);

        // Stuck-at-0 flip-flop
        do_reset();
        stuck = 1;
        push_cmd(2'b10); push_cmd(2'b11); push_cmd(2'b11);
        drain();
        chk("stuck_obs_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("stuck_q0", obs_q[0], 1); chk("stuck_q1", obs_q[1], 0); chk("stuck_q2", obs_q[2], 1);
        end
        chk("stuck_err", err, 2); chk("stuck_mis", mis, 1);

        // FIFO full with continuous valid
        do_reset();
        acc_cnt = 0; saw_low = 0;
        for (int t = 0; t < 8; t++) begin
            if (!rdy) saw_low = 1;
            step(1, 2'($urandom_range(0, 3)), 0);
            if (last_acc) acc_cnt++;
        end
        cmd_valid = 0;
        drain();
        chk("full_ready_dropped", saw_low, 1);
        chk("full_accepted", acc_cnt, 7);
        chk("full_cnt", cnt, acc_cnt);

        // clear_err colliding with a failing check
        do_reset();
        stuck = 1;
        for (int t = 0; t < 5; t++) push_cmd(2'b10);
        drain();
        chk("coll_pre_err", err, 5);
        push_cmd(2'b10);
        p = last_pop;
        for (int t = 0; t < 10 && n + 1 != p + 2; t++) step(0, 2'b00, 0);
        chk("coll_aligned", n + 1, p + 2);
        step(0, 2'b00, 1);
        chk("coll_err", err, 1); chk("coll_mis", mis, 1);
        step(0, 2'b00, 1);
        chk("clr_err", err, 0); chk("clr_mis", mis, 0);

        // Counter limits on the CNT_W=2 instance
        do_reset();
        stuck = 1;
        for (int t = 0; t < 6; t++) push_cmd(2'b11);
        drain();
        chk("lim_err2", err2, 3); chk("lim_cnt2", cnt2, 2);
        chk("lim_err8", err, 3);  chk("lim_cnt8", cnt, 6);

        // Random traffic with occasional corrupted read-back and clears
        do_reset();
        for (int t = 0; t < 400; t++) begin
            q_inv = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
        end
        q_inv = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
